control_sequencer: RTL
======================

# control_sequencer

Hardwired Moore control unit that sits directly upstream of `DataPath` and drives its control inputs. It replaces the hand-sequenced testbench stimulus with a real fetch/decode/execute state machine. It sequences T0–T7 per instruction from the opcode in `ir[31:27]`, and covers load/store, register ALU, immediate ALU, nop and halt.

## Interface
Parameters:
- `OP_ADD`, default 5'b00011: ALU op driven on `ops` for add and for address calculation.
- `OP_SUB`, default 5'b00100: ALU subtract op.
- `OP_AND`, default 5'b01010: ALU AND op.
- `OP_OR`, default 5'b01011: ALU OR op.

Ports:
- `clock`  in  1: single clock; all state changes on the rising edge.
- `clear`  in  1: reset, synchronous, active-low. 0 at a rising edge forces IDLE.
- `start`  in  1: leave IDLE and begin fetching.
- `ir`  in  32: IR contents from `DataPath`. Only bits 31:27 are used.
- `PCout, MARin, IncPC, RZin, RZLOout, PCin, Read, Write, MDRin, MDRout, IRin`  out  1 each: `DataPath` strobes.
- `gra, grb, grc, rin, rout, BAout, RYin, Cout`  out  1 each: register-select and bus strobes.
- `ops`  out  5: ALU operation; 5'b00000 when no ALU op is active.
- `present_state`  out  4: state code, for debug.
- `run`  out  1: high in every state except IDLE and HALT.
- `instr_done`  out  1: high during the last execute state of each instruction.
- `illegal`  out  1: sticky flag for an undefined opcode; cleared only by reset.

## Operation
- State codes: IDLE=0, T0..T7=1..8, HALT=9.
- Outputs are a pure function of `present_state` and the opcode. Every strobe is high for exactly one full cycle. Any strobe not listed for a state is 0.
- Opcodes (`ir[31:27]`):
  - ld=00000, ldi=00001, st=00010
  - add=00011, sub=00100, and=01010, or=01011
  - addi=01100, andi=01101, ori=01110
  - nop=11010, halt=11011
- Fetch, common to all instructions:
  - T0: PCout, MARin, IncPC, RZin.
  - T1: RZLOout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Register ALU (add/sub/and/or):
  - T3: grb, rout, RYin.
  - T4: grc, rout, RZin, ops=op.
  - T5: RZLOout, gra, rin, instr_done.
- Immediate ALU (addi/andi/ori):
  - T3: grb, rout, RYin.
  - T4: Cout, RZin, ops = OP_ADD / OP_AND / OP_OR respectively.
  - T5: RZLOout, gra, rin, instr_done.
- ldi:
  - T3: grb, BAout, RYin.
  - T4: Cout, RZin, ops=OP_ADD.
  - T5: RZLOout, gra, rin, instr_done.
- ld:
  - T3–T4: as ldi.
  - T5: RZLOout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, gra, rin, instr_done.
- st:
  - T3–T5: as ld.
  - T6: gra, rout, MDRin, with Read=0.
  - T7: Write, instr_done.
- nop: T2 asserts instr_done; next state is T0.
- halt: T2 asserts instr_done; next state is HALT. HALT holds all strobes at 0 and is left only by reset.
- Undefined opcode: treated as halt, and `illegal` is set on the T2→HALT edge.
- Transitions:
  - IDLE→T0 when `start`=1.
  - T0→T1→T2.
  - T2 → T3, T0 or HALT, by opcode.
  - After the last execute state → T0. No return to IDLE and no further wait on `start`.
- The opcode is read from `ir` in T3..T7; `ir` is stable because IRin is only asserted in T2. In T2 the opcode comes from `ir` as written at the T2 edge (see Timing).

## Timing
- Reset: `clear`=0 at a rising edge gives, in the next cycle:
  - state IDLE; all strobes 0; ops=0;
  - run=0, instr_done=0, illegal=0.
  - This holds mid-instruction, including in T6 of st: Write must not assert.
- Latency: `start` sampled high at edge N puts T0 in cycle N+1.
- Instruction lengths, in cycles from T0 through the last execute state:
  - nop/halt: 3
  - ALU, immediate, ldi: 6
  - ld/st: 8
- Back-to-back: the cycle after `instr_done` is always T0 (except halt/illegal, which go to HALT).
- T2 decision: IR is written at the end of T2. The sequencer therefore decodes the next state from the opcode on `ir` combinationally during T2. `DataPath` must present MDR on `ir` during T2, because IRin is transparent-to-output at the edge. Decoding from MDR directly is allowed as an equivalent.
- `start` is ignored outside IDLE. `clear` has priority over `start`.

## Test plan
- Reset and idle: clear=0 for 2 cycles, then 1, with start=0 → state=0, all outputs 0, run=0 for 5 cycles.
- add R1,R2,R3 (ir=0x18918000), start pulse:
  - states go 1..6, then back to 1;
  - ops=00011 only in T4; grc=1 only in T4; instr_done only in T5.
- ori (opcode 01110) → T4 has Cout=1, RZin=1, ops=01011; T3 has grb, rout, RYin.
- ld then st:
  - ld: state reaches 8 with gra and rin in T7.
  - st: Write=1 only in T7; Read=0 in T6 with MDRin=1.
- halt (0xD8000000) → instr_done in T2; state=9 held for 10 cycles; run=0; illegal=0. Opcode 11111 → state 9 with illegal=1.
- Reset mid-st (clear=0 in T6) → next cycle state=0, Write never asserted, illegal cleared.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for DataPath.
// Sequences fetch/decode/execute states T0..T7 from the opcode in ir[31:27].
module control_sequencer #(
    parameter logic [4:0] OP_ADD = 5'b00011,
    parameter logic [4:0] OP_SUB = 5'b00100,
    parameter logic [4:0] OP_AND = 5'b01010,
    parameter logic [4:0] OP_OR  = 5'b01011
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] ir,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        RZin,
    output logic        RZLOout,
    output logic        PCin,
    output logic        Read,
    output logic        Write,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        rin,
    output logic        rout,
    output logic        BAout,
    output logic        RYin,
    output logic        Cout,
    output logic [4:0]  ops,
    output logic [3:0]  present_state,
    output logic        run,
    output logic        instr_done,
    output logic        illegal
);
    typedef enum logic [3:0] {
        IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
        T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, T7 = 4'd8, HALT = 4'd9
    } state_t;

    localparam logic [4:0] C_LD   = 5'b00000;
    localparam logic [4:0] C_LDI  = 5'b00001;
    localparam logic [4:0] C_ST   = 5'b00010;
    localparam logic [4:0] C_ADD  = 5'b00011;
    localparam logic [4:0] C_SUB  = 5'b00100;
    localparam logic [4:0] C_AND  = 5'b01010;
    localparam logic [4:0] C_OR   = 5'b01011;
    localparam logic [4:0] C_ADDI = 5'b01100;
    localparam logic [4:0] C_ANDI = 5'b01101;
    localparam logic [4:0] C_ORI  = 5'b01110;
    localparam logic [4:0] C_NOP  = 5'b11010;
    localparam logic [4:0] C_HALT = 5'b11011;

    state_t state, nxt;
    logic [4:0] opc;
    logic [4:0] alu_op;
    logic is_ld, is_ldi, is_st, is_ralu, is_imm, is_nop, is_halt;
    logic is_mem, is_long, is_exec, is_bad;
    logic unused_ir;

    assign opc       = ir[31:27];
    assign unused_ir = ^ir[26:0];

    assign is_ld   = (opc == C_LD);
    assign is_ldi  = (opc == C_LDI);
    assign is_st   = (opc == C_ST);
    assign is_ralu = (opc == C_ADD) || (opc == C_SUB) ||
                     (opc == C_AND) || (opc == C_OR);
    assign is_imm  = (opc == C_ADDI) || (opc == C_ANDI) ||
                     (opc == C_ORI);
    assign is_nop  = (opc == C_NOP);
    assign is_halt = (opc == C_HALT);
    assign is_mem  = is_ld || is_ldi || is_st;
    assign is_long = is_ld || is_st;
    assign is_exec = is_mem || is_ralu || is_imm;
    assign is_bad  = !(is_exec || is_nop || is_halt);

    always_comb begin
        case (opc)
            C_SUB:          alu_op = OP_SUB;
            C_AND, C_ANDI:  alu_op = OP_AND;
            C_OR, C_ORI:    alu_op = OP_OR;
            default:        alu_op = OP_ADD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state   <= IDLE;
            illegal <= 1'b0;
        end else begin
            state <= nxt;
            if (state == T2 && is_bad)
                illegal <= 1'b1;
        end
    end

    // In T2 the opcode is MDR shown through ir, so the decision is combinational.
    always_comb begin
        case (state)
            IDLE:    nxt = start ? T0 : IDLE;
            T0:      nxt = T1;
            T1:      nxt = T2;
            T2:      nxt = is_exec ? T3 : (is_nop ? T0 : HALT);
            T3:      nxt = T4;
            T4:      nxt = T5;
            T5:      nxt = is_long ? T6 : T0;
            T6:      nxt = T7;
            T7:      nxt = T0;
            HALT:    nxt = HALT;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; RZin = 1'b0;
        RZLOout = 1'b0; PCin = 1'b0; Read = 1'b0; Write = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
        gra = 1'b0; grb = 1'b0; grc = 1'b0; rin = 1'b0; rout = 1'b0;
        BAout = 1'b0; RYin = 1'b0; Cout = 1'b0;
        ops = 5'b00000;
        instr_done = 1'b0;
        case (state)
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1;
            end
            T1: begin
                RZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                instr_done = !is_exec;
            end
            T3: begin
                grb = 1'b1; RYin = 1'b1;
                BAout = is_mem;
                rout = !is_mem;
            end
            T4: begin
                RZin = 1'b1;
                ops = alu_op;
                grc = is_ralu;
                rout = is_ralu;
                Cout = !is_ralu;
            end
            T5: begin
                RZLOout = 1'b1;
                MARin = is_long;
                gra = !is_long;
                rin = !is_long;
                instr_done = !is_long;
            end
            T6: begin
                MDRin = 1'b1;
                Read = is_ld;
                gra = is_st;
                rout = is_st;
            end
            T7: begin
                instr_done = 1'b1;
                Write = is_st;
                MDRout = is_ld;
                gra = is_ld;
                rin = is_ld;
            end
            default: ;
        endcase
    end

    assign present_state = state;
    assign run = (state != IDLE) && (state != HALT);
endmodule
